// File: rtl/vga_frame_scheduler.sv
// VGA timing generator with registered sync/blank decode and frame counter, plus a
// req/grant/done scheduler that opens the animation-state write window only in vblank.
module vga_frame_scheduler #(
   parameter int H_DISPLAY = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter bit SYNC_NEG  = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   output logic [9:0] hpos,
   output logic [9:0] vpos,
   output logic       hsync,
   output logic       vsync,
   output logic       display_on,
   output logic [7:0] frame,
   output logic       line_start,
   output logic       frame_start,
   input  logic       upd_req,
   input  logic       upd_done,
   output logic       upd_grant,
   output logic       upd_abort
);
   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
   localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
   localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_GRANT} state_t;

   logic [9:0] hpos_q, hpos_d;
   logic [9:0] vpos_q, vpos_d;
   logic [7:0] frame_q, frame_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       de_q, de_d;
   state_t     state_q;
   logic       grant_q;
   logic       abort_q;
   logic       h_wrap;
   logic       frame_end;
   logic       vblank;

   always_comb begin
      h_wrap    = (hpos_q == H_LAST);
      frame_end = h_wrap && (vpos_q == V_LAST);
      vblank    = (vpos_q >= V_VIS);
      hpos_d    = h_wrap ? 10'd0 : hpos_q + 10'd1;
      vpos_d    = vpos_q;
      frame_d   = frame_q;
      if (h_wrap) begin
         vpos_d = frame_end ? 10'd0 : vpos_q + 10'd1;
      end
      if (frame_end) begin
         frame_d = frame_q + 8'd1;
      end
      de_d    = (hpos_q < H_VIS) && (vpos_q < V_VIS);
      hsync_d = ((hpos_q >= HS_FIRST) && (hpos_q <= HS_LAST)) ^ SYNC_NEG;
      vsync_d = ((vpos_q >= VS_FIRST) && (vpos_q <= VS_LAST)) ^ SYNC_NEG;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hpos_q  <= 10'd0;
         vpos_q  <= 10'd0;
         frame_q <= 8'd0;
         hsync_q <= SYNC_NEG;
         vsync_q <= SYNC_NEG;
         de_q    <= 1'b0;
      end else if (ena) begin
         hpos_q  <= hpos_d;
         vpos_q  <= vpos_d;
         frame_q <= frame_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         de_q    <= de_d;
      end
   end

   // The window is closed on the last cycle of the frame so the registered grant is
   // already low when vpos returns to 0; a grant is never opened on that same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         grant_q <= 1'b0;
         abort_q <= 1'b0;
      end else if (ena) begin
         abort_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (upd_req) begin
                  if (vblank && !frame_end) begin
                     state_q <= ST_GRANT;
                     grant_q <= 1'b1;
                  end else begin
                     state_q <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (!upd_req) begin
                  state_q <= ST_IDLE;
               end else if (vblank && !frame_end) begin
                  state_q <= ST_GRANT;
                  grant_q <= 1'b1;
               end
            end
            ST_GRANT: begin
               if (upd_done) begin
                  state_q <= ST_IDLE;
                  grant_q <= 1'b0;
               end else if (frame_end) begin
                  state_q <= ST_IDLE;
                  grant_q <= 1'b0;
                  abort_q <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               grant_q <= 1'b0;
            end
         endcase
      end
   end

   assign hpos        = hpos_q;
   assign vpos        = vpos_q;
   assign frame       = frame_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign display_on  = de_q;
   assign line_start  = ena && !rst && (hpos_q == 10'd0);
   assign frame_start = line_start && (vpos_q == 10'd0);
   assign upd_grant   = grant_q;
   assign upd_abort   = abort_q && ena;

endmodule

// File: doc/vga_frame_scheduler.md
Name: vga_frame_scheduler

Overview:
Generates 640x480@60 Hz VGA timing (25.175 MHz pixel clock) from one clock: pixel/line counters, sync pulses, display-enable and frame counter. It also schedules access to shared animation state. The renderer's update engine may modify that state only during vertical blanking, through a req/grant/done handshake. The block sits between the top-level pin mux (sync and RGB out) and the pixel generator / animation logic.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch
H_SYNC, 96, hsync pulse width
H_BACK, 48, horizontal back porch
V_DISPLAY, 480, visible lines
V_FRONT, 10, vertical front porch
V_SYNC, 2, vsync pulse width
V_BACK, 33, vertical back porch
SYNC_NEG, 1, 1 = sync pulses active-low

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous active-high reset
ena  in  1  count enable; 0 freezes the block
hpos  out  10  current pixel column, 0..H_TOTAL-1
vpos  out  10  current line, 0..V_TOTAL-1
hsync  out  1  horizontal sync, registered, 1-cycle lag vs hpos
vsync  out  1  vertical sync, registered, 1-cycle lag vs vpos
display_on  out  1  visible-area flag, registered, 1-cycle lag
frame  out  8  frame counter, wraps mod 256
line_start  out  1  1-cycle pulse when hpos==0
frame_start  out  1  1-cycle pulse when hpos==0 and vpos==0
upd_req  in  1  update engine requests state-write window
upd_done  in  1  update engine finished; sampled only while granted
upd_grant  out  1  write window open
upd_abort  out  1  1-cycle pulse: grant revoked before done

Behaviour:
- H_TOTAL = sum of H_* parameters (800). V_TOTAL = sum of V_* parameters (525). Compute both at elaboration.
- Reset (asynchronous, while rst=1):
  - hpos=0, vpos=0, frame=0.
  - hsync and vsync inactive (1 when SYNC_NEG=1).
  - display_on=0, line_start=0, frame_start=0.
  - FSM in IDLE; upd_grant=0, upd_abort=0.
- Counters, per cycle with ena=1:
  - hpos increments.
  - At hpos==H_TOTAL-1: hpos->0 and vpos increments.
  - At vpos==V_TOTAL-1 with that hpos wrap: vpos->0 and frame increments (255->0).
- ena=0: all registers hold; line_start, frame_start and upd_abort forced 0; handshake FSM holds.
- Decode is registered, so outputs at cycle t+1 reflect hpos/vpos at cycle t:
  - display_on = (hpos<H_DISPLAY) && (vpos<V_DISPLAY).
  - hsync active for hpos in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = [656,751].
  - vsync active for vpos in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] = [490,491].
- line_start and frame_start are combinational from the counters, gated by ena.
- vblank is defined as vpos>=V_DISPLAY.
- Handshake FSM, states IDLE, WAIT, GRANT:
  - IDLE: upd_req & vblank -> GRANT. upd_req & !vblank -> WAIT.
  - WAIT: upd_req dropped -> IDLE. Entering vblank (vpos==V_DISPLAY, hpos==0) -> GRANT.
  - GRANT: upd_grant=1. upd_done=1 -> IDLE, upd_grant falls next cycle.
  - GRANT at frame_start without done -> IDLE, with upd_abort pulsed exactly 1 cycle at the same edge upd_grant falls.
  - done and frame_start in the same cycle: done wins, no abort.
  - upd_req dropped in GRANT without done: grant held until done or frame_start.
  - upd_grant is registered and never asserted while vpos<V_DISPLAY.
- Reset mid-grant: upd_grant drops immediately (asynchronous) and no abort pulse is issued.

Test Plan:
- Reset, then ena=1 for 800*525 cycles:
  - hsync low for exactly 96 cycles per line, rising 1 cycle after hpos 751.
  - vsync low exactly 2 lines per frame.
  - display_on high 640*480 cycles per frame.
  - frame goes 0->1.
- Run 256 frames (can use reduced parameters, e.g. H 8/1/2/1, V 6/1/1/1) -> frame wraps 255->0 and frame_start pulses exactly once per frame.
- upd_req raised at vpos=100 -> FSM in WAIT, upd_grant=0 until vpos=480, then upd_grant=1 one cycle after hpos==0 of line 480. upd_done at vpos=485 -> grant low next cycle, upd_abort stays 0.
- upd_req held, no upd_done, through line 524 -> at frame_start upd_grant falls and upd_abort is high exactly 1 cycle.
- ena toggled low for 37 cycles mid-line at hpos=300 -> hpos, vpos, sync outputs and grant frozen, strobes 0; timing resumes from hpos=300.
- rst asserted during GRANT at vpos=500 -> all outputs at reset values immediately, no abort. After release hpos counts from 0.
